// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline forwarding, stall/flush control and imem-wait timeout tracking.
// Define HAZARD_PERF_CNT_EN to build the StallCnt/FlushCnt performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [2:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        ImemReadyF,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [2:0]  HazState,
  output logic        ImemTimeout,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);
  typedef enum logic [2:0] {BOOT, RUN, LDUSE, IMWAIT, REDIRECT} hazStateT;
  hazStateT state, nextState;
  logic [CW-1:0] waitCnt, waitNext;
  logic loadUse, imemWait, boot;
  always_comb begin
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    loadUse = ResultSrcE == 3'b001 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    imemWait = ~ImemReadyF;
    boot = reset || state == BOOT;
    {StallF, StallD, FlushD, FlushE} = boot     ? 4'b1011 :
                                       PCSrcE   ? 4'b0011 :
                                       loadUse  ? 4'b1101 :
                                       imemWait ? 4'b1010 : 4'b0000;
    nextState = PCSrcE ? REDIRECT : loadUse ? LDUSE : imemWait ? IMWAIT : RUN;
    // Waits seen during BOOT do not count toward the timeout.
    waitNext = (!imemWait || PCSrcE) ? '0 :
               (state == BOOT || waitCnt == TMAX) ? waitCnt : waitCnt + 1'b1;
  end
  assign HazState = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      waitCnt <= '0;
      ImemTimeout <= 1'b0;
    end else begin
      state <= nextState;
      waitCnt <= waitNext;
      ImemTimeout <= ImemTimeout | (waitNext == TMAX);
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      StallCnt <= StallCnt + 32'(StallF);
      FlushCnt <= FlushCnt + 32'(PCSrcE && state != BOOT);
    end
  end
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table, timeout/counter sequences and a randomized model comparison.
module tb_hazard_ctrl;
  localparam int TO = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rwm, rww;
    logic [2:0] rsrc;
    logic pc, rdy;
  } inT;
  typedef struct {
    inT i;
    logic [1:0] fa, fb;
    logic [3:0] ctl;
    logic [2:0] st;
  } vecT;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, ImemReadyF;
  logic [2:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE, ImemTimeout;
  logic [2:0] HazState;
  logic [31:0] StallCnt, FlushCnt;
  int checks = 0, failures = 0;
  vecT tbl[$];
  logic [3:0] ctlOf [5] = '{4'b1011, 4'b0000, 4'b1101, 4'b1010, 4'b0011};
  hazard_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .ImemReadyF(ImemReadyF),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .HazState(HazState), .ImemTimeout(ImemTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt));
  always #5 clk = ~clk;
  function automatic inT mkIn(logic rst, logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              logic rwm, rww, logic [2:0] rsrc, logic pc, rdy);
    inT v;
    v.rst = rst; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
    v.rsrc = rsrc; v.pc = pc; v.rdy = rdy;
    return v;
  endfunction
  function automatic logic [1:0] fwdOf(logic [4:0] rs, inT v);
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic addRow(inT i, logic [1:0] fa, fb, logic [3:0] ctl, logic [2:0] st);
    vecT r;
    r.i = i; r.fa = fa; r.fb = fb; r.ctl = ctl; r.st = st;
    tbl.push_back(r);
  endtask
  task automatic drive(inT v);
    reset = v.rst; Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.rsrc; PCSrcE = v.pc; ImemReadyF = v.rdy;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(inT v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask
  initial begin
    inT v, idle, lu;
    int mSt, mWait, cause;
    bit mTo, luM;
    logic [31:0] mSc, mFc, s0, f0;
    logic [3:0] eCtl;
    idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
    addRow(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1), 2'b00, 2'b00, 4'b1011, 3'd0);
    addRow(idle, 2'b00, 2'b00, 4'b1011, 3'd0);
    addRow(idle, 2'b00, 2'b00, 4'b0000, 3'd1);
    addRow(mkIn(0, 0, 0, 5, 0, 0, 5, 5, 1, 1, 3'b000, 0, 1), 2'b10, 2'b00, 4'b0000, 3'd1);
    addRow(mkIn(0, 0, 0, 5, 0, 0, 5, 5, 0, 1, 3'b000, 0, 1), 2'b01, 2'b00, 4'b0000, 3'd1);
    addRow(mkIn(0, 0, 0, 0, 5, 0, 5, 0, 1, 0, 3'b000, 0, 1), 2'b00, 2'b10, 4'b0000, 3'd1);
    addRow(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0, 1), 2'b00, 2'b00, 4'b0000, 3'd1);
    addRow(mkIn(0, 0, 7, 0, 0, 7, 0, 0, 0, 0, 3'b001, 0, 0), 2'b00, 2'b00, 4'b1101, 3'd1);
    addRow(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1), 2'b00, 2'b00, 4'b0000, 3'd2);
    addRow(idle, 2'b00, 2'b00, 4'b0000, 3'd1);
    addRow(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0), 2'b00, 2'b00, 4'b1010, 3'd1);
    addRow(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0), 2'b00, 2'b00, 4'b0011, 3'd3);
    addRow(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0), 2'b00, 2'b00, 4'b1010, 3'd4);
    addRow(idle, 2'b00, 2'b00, 4'b0000, 3'd3);
    addRow(mkIn(0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 3'b001, 1, 1), 2'b00, 2'b00, 4'b0011, 3'd1);
    addRow(mkIn(0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 3'b001, 0, 1), 2'b00, 2'b00, 4'b1101, 3'd4);
    addRow(mkIn(1, 3, 0, 0, 0, 3, 0, 0, 0, 0, 3'b001, 0, 0), 2'b00, 2'b00, 4'b1011, 3'd2);
    addRow(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0), 2'b00, 2'b00, 4'b1011, 3'd0);
    addRow(idle, 2'b00, 2'b00, 4'b0000, 3'd3);
    addRow(mkIn(0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 3'b011, 0, 1), 2'b00, 2'b00, 4'b0000, 3'd1);
    drive(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1));
    repeat (2) @(posedge clk);
    foreach (tbl[n]) begin
      @(negedge clk);
      drive(tbl[n].i);
      #1;
      chk($sformatf("tbl%0d_fwdA", n), 32'(ForwardAE), 32'(tbl[n].fa));
      chk($sformatf("tbl%0d_fwdB", n), 32'(ForwardBE), 32'(tbl[n].fb));
      chk($sformatf("tbl%0d_ctl", n), 32'({StallF, StallD, FlushD, FlushE}), 32'(tbl[n].ctl));
      chk($sformatf("tbl%0d_state", n), 32'(HazState), 32'(tbl[n].st));
      chk($sformatf("tbl%0d_timeout", n), 32'(ImemTimeout), 32'd0);
    end
    // Timeout: sticky flag after the TO-th counted wait cycle.
    cyc(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1));
    cyc(idle);
    for (int w = 1; w <= 6; w++) begin
      cyc(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
      chk($sformatf("to_wait%0d", w), 32'(ImemTimeout), 32'(w >= TO));
    end
    for (int k = 0; k < 3; k++) begin
      cyc(idle);
      chk("to_sticky", 32'(ImemTimeout), 32'd1);
    end
    cyc(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1));
    chk("to_reset", 32'(ImemTimeout), 32'd0);
    // Performance counters: 3 load-use cycles and 2 branches after boot.
    chk("cnt_rst_stall", StallCnt, 32'd0);
    chk("cnt_rst_flush", FlushCnt, 32'd0);
    cyc(idle);
    s0 = StallCnt;
    f0 = FlushCnt;
    lu = mkIn(0, 7, 0, 0, 0, 7, 0, 0, 0, 0, 3'b001, 0, 1);
    repeat (3) cyc(lu);
    repeat (2) cyc(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1));
    cyc(idle);
    chk("cnt_stall_delta", StallCnt - s0, PERF ? 32'd3 : 32'd0);
    chk("cnt_flush_delta", FlushCnt - f0, PERF ? 32'd2 : 32'd0);
    // Randomized run against a rule-level model.
    cyc(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1));
    mSt = 0; mWait = 0; mTo = 0; mSc = 0; mFc = 0;
    for (int n = 0; n < 3000; n++) begin
      v = mkIn($urandom_range(0, 99) < 3, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               $urandom_range(0, 1) ? 3'b001 : 3'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 15, $urandom_range(0, 99) >= 40);
      @(negedge clk);
      drive(v);
      #1;
      luM = v.rsrc == 3'b001 && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d);
      cause = v.pc ? 4 : luM ? 2 : !v.rdy ? 3 : 1;
      eCtl = ctlOf[(v.rst || mSt == 0) ? 0 : cause];
      chk("rnd_fwdA", 32'(ForwardAE), 32'(fwdOf(v.rs1e, v)));
      chk("rnd_fwdB", 32'(ForwardBE), 32'(fwdOf(v.rs2e, v)));
      chk("rnd_ctl", 32'({StallF, StallD, FlushD, FlushE}), 32'(eCtl));
      chk("rnd_state", 32'(HazState), 32'(mSt));
      chk("rnd_timeout", 32'(ImemTimeout), 32'(mTo));
      chk("rnd_stallcnt", StallCnt, PERF ? mSc : 32'd0);
      chk("rnd_flushcnt", FlushCnt, PERF ? mFc : 32'd0);
      @(posedge clk);
      if (v.rst) begin
        mSt = 0; mWait = 0; mTo = 0; mSc = 0; mFc = 0;
      end else begin
        mSc += 32'(eCtl[3]);
        mFc += 32'(v.pc && mSt != 0);
        if (v.rdy || v.pc) mWait = 0;
        else if (mSt != 0 && mWait < TO) mWait++;
        if (mWait == TO) mTo = 1;
        mSt = cause;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, consecutive imem-wait cycles before timeout flag.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  5 each  register indices from datapath stages.
REQ-005 SHALL have: RegWriteM, RegWriteW  in  1  write-enable of M/W stage instructions.
REQ-006 SHALL have: ResultSrcE  in  3  E-stage result select; 3'b001 = load.
REQ-007 SHALL have: PCSrcE  in  1  taken branch/jump in E.
REQ-008 SHALL have: ImemReadyF  in  1  instruction memory has valid InstrF this cycle.
REQ-009 SHALL have: ForwardAE, ForwardBE  out  2  00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM.
REQ-010 SHALL have: StallF, StallD, FlushD, FlushE  out  1 each  pipeline register controls.
REQ-011 SHALL have: HazState  out  3  registered FSM state.
REQ-012 SHALL have: ImemTimeout  out  1  sticky imem timeout flag.
REQ-013 SHALL have: StallCnt, FlushCnt  out  32 each  performance counters.

Function
REQ-014 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00 (M priority over W); ForwardBE identical using Rs2E.
REQ-015 Load-use (LU) SHALL be ResultSrcE==3'b001 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-016 Imem wait (IW) SHALL be ~ImemReadyF.
REQ-017 Controls SHALL be combinational, priority BOOT > PCSrcE > LU > IW > none.
REQ-018 BOOT state: StallF=1, StallD=0, FlushD=1, FlushE=1.
REQ-019 PCSrcE=1: StallF=0, StallD=0, FlushD=1, FlushE=1, regardless of LU/IW (PC takes target even during imem wait).
REQ-020 LU (no branch): StallF=1, StallD=1, FlushE=1, FlushD=0, regardless of IW.
REQ-021 IW only: StallF=1, StallD=0, FlushD=1, FlushE=0 (bubble into D).
REQ-022 None: all four controls 0.
REQ-023 FSM states: BOOT=0, RUN=1, LDUSE=2, IMWAIT=3, REDIRECT=4; next state = cause selected this cycle per REQ-017 (none -> RUN); BOOT lasts exactly one cycle then leaves via the same rule.
REQ-024 HazState SHALL equal the FSM state register.
REQ-025 Wait counter SHALL increment each cycle IW is 1 and state != BOOT, clear when IW is 0 or PCSrcE is 1, saturate at TIMEOUT_CYC.
REQ-026 ImemTimeout SHALL set on the cycle the wait counter reaches TIMEOUT_CYC and stay 1 until reset; it SHALL NOT alter controls.
REQ-027 Rd/Rs index 0 SHALL never produce forwarding or LU.

Reset
REQ-028 On reset: state=BOOT, wait counter=0, ImemTimeout=0, StallCnt=FlushCnt=0; reset mid-operation SHALL abandon any stall/wait immediately.
REQ-029 While reset is 1, controls SHALL be driven as BOOT (REQ-018).

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: StallCnt +1 each non-reset cycle StallF=1; FlushCnt +1 each non-reset cycle with PCSrcE=1 in a non-BOOT state; both wrap 32'hFFFFFFFF -> 0.
REQ-031 Macro undefined: counters not built, StallCnt and FlushCnt tied to 0; all other behaviour unchanged.

Verification
REQ-032 Release reset, ImemReadyF=1 -> cycle 0 BOOT controls (1,0,1,1), HazState=0; cycle 1 all controls 0, HazState=1.
REQ-033 RdM=5 RegWriteM=1, RdW=5 RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; drop RegWriteM -> ForwardAE=01.
REQ-034 ResultSrcE=001, RdE=7, Rs2D=7, ImemReadyF=0 -> StallF=1, StallD=1, FlushE=1, FlushD=0, next HazState=2; RdE=0 -> no stall.
REQ-035 ImemReadyF=0 for 3 cycles, PCSrcE=1 on cycle 2 -> cycles 1,3: (1,0,1,0); cycle 2: (0,0,1,1), next HazState=4; wait counter cleared.
REQ-036 TIMEOUT_CYC=4, ImemReadyF=0 for 6 cycles -> ImemTimeout rises on 4th wait cycle, stays 1 after ImemReadyF=1, clears only on reset.
REQ-037 With HAZARD_PERF_CNT_EN, 3 LU cycles + 2 branches -> StallCnt=3, FlushCnt=2; without macro both read 0.
